// File: rtl/ro_window_compare_if.sv
// Handshake and data bundle between a controller, two Counting_circuit
// counters and the ro_window_compare response generator.
interface ro_window_compare_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned NBITS = 8
);
   logic             start;
   logic [CNT_W-1:0] value_a;
   logic [CNT_W-1:0] value_b;
   logic             busy;
   logic             done;
   logic [NBITS-1:0] response;
   logic             tie_err;

   modport master (
      output start, value_a, value_b,
      input  busy, done, response, tie_err
   );

   modport slave (
      input  start, value_a, value_b,
      output busy, done, response, tie_err
   );
endinterface

// File: rtl/ro_window_compare.sv
// Ring-oscillator window comparator: measures two counter deltas over WINDOW
// clk cycles, NBITS times, and assembles a response word. Optional: RO_TIE_RETRY_EN.
module ro_window_compare #(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned WINDOW = 64,
   parameter int unsigned NBITS  = 8
) (
   input logic               clk,
   input logic               rst,
   ro_window_compare_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      MEAS,
      CMP,
      DONE
   } state_t;

   localparam int unsigned TW = $clog2(WINDOW);
   localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [TW-1:0] T_LOAD = TW'(WINDOW - 1);
   localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);

   state_t           state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic [BW-1:0]    bit_cnt, bit_cnt_n;
   logic [CNT_W-1:0] start_a, start_a_n;
   logic [CNT_W-1:0] start_b, start_b_n;
   logic [CNT_W-1:0] end_a, end_a_n;
   logic [CNT_W-1:0] end_b, end_b_n;
   logic [NBITS-1:0] response, response_n;
   logic             tie_err, tie_err_n;
`ifdef RO_TIE_RETRY_EN
   logic [1:0]       retry_cnt, retry_cnt_n;
`endif

   logic [CNT_W-1:0] delta_a;
   logic [CNT_W-1:0] delta_b;
   logic             tie;
   logic             win;
   logic [NBITS:0]   shifted;
   logic             record;

   // Modular subtraction absorbs a single counter wrap inside the window.
   assign delta_a = end_a - start_a;
   assign delta_b = end_b - start_b;
   assign tie     = (delta_a == delta_b);
   assign win     = (delta_a > delta_b);
   // Widened by one bit so the shift is legal for NBITS == 1 too.
   assign shifted = {response, win};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         bit_cnt   <= '0;
         start_a   <= '0;
         start_b   <= '0;
         end_a     <= '0;
         end_b     <= '0;
         response  <= '0;
         tie_err   <= 1'b0;
`ifdef RO_TIE_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         bit_cnt   <= bit_cnt_n;
         start_a   <= start_a_n;
         start_b   <= start_b_n;
         end_a     <= end_a_n;
         end_b     <= end_b_n;
         response  <= response_n;
         tie_err   <= tie_err_n;
`ifdef RO_TIE_RETRY_EN
         retry_cnt <= retry_cnt_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      bit_cnt_n   = bit_cnt;
      start_a_n   = start_a;
      start_b_n   = start_b;
      end_a_n     = end_a;
      end_b_n     = end_b;
      response_n  = response;
      tie_err_n   = tie_err;
      record      = 1'b0;
`ifdef RO_TIE_RETRY_EN
      retry_cnt_n = retry_cnt;
`endif

      case (state)
         IDLE: begin
            if (bus.start) begin
               start_a_n  = bus.value_a;
               start_b_n  = bus.value_b;
               timer_n    = T_LOAD;
               bit_cnt_n  = '0;
               response_n = '0;
               tie_err_n  = 1'b0;
`ifdef RO_TIE_RETRY_EN
               retry_cnt_n = '0;
`endif
               state_n    = MEAS;
            end
         end

         MEAS: begin
            if (timer != '0) begin
               timer_n = timer - TW'(1);
            end else begin
               end_a_n = bus.value_a;
               end_b_n = bus.value_b;
               state_n = CMP;
            end
         end

         CMP: begin
            record = 1'b1;
`ifdef RO_TIE_RETRY_EN
            // A tie re-measures the same bit until three retries are spent.
            if (tie && (retry_cnt != 2'd3)) begin
               record      = 1'b0;
               retry_cnt_n = retry_cnt + 2'd1;
               start_a_n   = bus.value_a;
               start_b_n   = bus.value_b;
               timer_n     = T_LOAD;
               state_n     = MEAS;
            end
`endif
            if (record) begin
               response_n = shifted[NBITS-1:0];
               if (tie) begin
                  tie_err_n = 1'b1;
               end
`ifdef RO_TIE_RETRY_EN
               retry_cnt_n = '0;
`endif
               if (bit_cnt == B_LAST) begin
                  state_n = DONE;
               end else begin
                  bit_cnt_n = bit_cnt + BW'(1);
                  start_a_n = bus.value_a;
                  start_b_n = bus.value_b;
                  timer_n   = T_LOAD;
                  state_n   = MEAS;
               end
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy     = (state == MEAS) || (state == CMP);
   assign bus.done     = (state == DONE);
   assign bus.response = response;
   assign bus.tie_err  = tie_err;

endmodule
